i2c_req_arbiter: RTL and testbench
==================================

Name: i2c_req_arbiter

Overview:
- Shares one i2c_master between N_REQ independent requesters (sensor poller, config loader, host bridge, ...).
- Arbitrates round-robin and latches the winner's address, data and direction.
- Drives the master's start/addr/tx_byte/rw handshake and routes the result (rx_byte, ack_error) back to the winning requester.
- Sits directly in front of i2c_master; requesters never touch the master ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 65535, max clk cycles from start assertion to master idle before abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester transaction request, level.
- req_addr  in  7*N_REQ  packed 7-bit slave addresses; requester i at [7i+6:7i].
- req_data  in  8*N_REQ  packed write bytes; requester i at [8i+7:8i].
- req_rw  in  N_REQ  1=read, 0=write.
- gnt  out  N_REQ  one-hot; high from grant until the done pulse.
- done  out  N_REQ  one-cycle pulse to the granted requester at completion.
- resp_data  out  8  read byte; valid while done is high.
- resp_err  out  1  slave NACK or timeout; valid while done is high.
- resp_timeout  out  1  abort was caused by timeout; valid while done is high.
- m_start  out  1  to i2c_master.start.
- m_addr  out  7  to i2c_master.addr.
- m_tx_byte  out  8  to i2c_master.tx_byte.
- m_rw  out  1  to i2c_master.rw.
- m_rx_byte  in  8  from i2c_master.rx_byte.
- m_rx_valid  in  1  from i2c_master.rx_valid.
- m_busy  in  1  from i2c_master.busy.
- m_ack_error  in  1  from i2c_master.ack_error.

Behaviour:
- Reset values: gnt=0, done=0, resp_data=0, resp_err=0, resp_timeout=0, m_start=0, m_addr=0, m_tx_byte=0, m_rw=0. rr_ptr=N_REQ-1, so requester 0 has first priority. State=IDLE, timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, XFER, RESP.
- IDLE:
  - Arbitrate only if req!=0 and m_busy=0.
  - Winner = first set bit searching upward from rr_ptr+1, with wrap-around.
  - On the next edge: gnt[w]=1; latch req_addr/req_data/req_rw of w into m_addr/m_tx_byte/m_rw; m_start=1; rr_ptr=w; counter=0; go to ISSUE.
  - Latency: req rising -> gnt and m_start high 1 cycle later.
- ISSUE:
  - Hold m_start=1 with stable m_addr/m_tx_byte/m_rw.
  - On m_busy=1: m_start=0 on the next edge, go to XFER.
- XFER:
  - On m_rx_valid=1: capture m_rx_byte into resp_data.
  - On m_busy=0: capture m_ack_error into resp_err; if m_rw=1 and no rx_valid was seen, resp_data=m_rx_byte. Go to RESP.
- RESP:
  - done[w]=1 for exactly one cycle; gnt drops on the same edge that done drops.
  - Return to IDLE. Arbitration can occur in the cycle after done, giving 1 idle cycle between transactions.
- Timeout:
  - Counter increments each cycle in ISSUE and XFER.
  - On reaching TIMEOUT_CYC-1: m_start=0, resp_err=1, resp_timeout=1, go to RESP.
  - If m_busy stays high after a timeout, IDLE withholds new grants until it falls.
- Requester rules:
  - Fields are sampled only on the grant edge; req may drop or change after gnt.
  - Dropping req mid-transaction does not abort; done still pulses.
  - A requester holding req high after done re-enters arbitration; round-robin prevents starvation.
- Write transactions: resp_data=0.
- Simultaneous requests: exactly one grant per arbitration; the others wait, with no ordering beyond round-robin.
- m_busy already high in IDLE (external or aborted transfer): no grant, m_start never asserted.
- Reset mid-transaction: all outputs return to reset values immediately. The master is reset separately; no done pulse is generated.

Decomposition:
- Shared package i2c_pkg:
  - arb_state_t enum (IDLE, ISSUE, XFER, RESP);
  - I2C_ADDR_W=7, I2C_DATA_W=8;
  - the i2c_master state encodings already used by benches.
- Sub-module rr_arbiter (req, rr_ptr -> one-hot winner, combinational plus valid flag). It is reusable for the planned multi-bus version.

Test Plan:
- Single write: req[0]=1, addr 0x50, data 0xA5, rw=0 -> gnt[0] one cycle later; m_addr=0x50, m_tx_byte=0xA5; one done[0] pulse; resp_err=0.
- Read-back: after the write, req[2] read at 0x50, slave echoes 0xA5 -> done[2] with resp_data=0xA5, resp_err=0.
- Contention: req=4'b1111 held high -> grant order 0,1,2,3,0; each done precedes the next gnt by 1 cycle; never two gnt bits high.
- NACK: slave releases SDA on the address ACK -> done with resp_err=1, resp_timeout=0; next request still served.
- Timeout: TIMEOUT_CYC=100, m_busy tied low -> m_start drops, done at cycle 100 after grant, resp_err=1, resp_timeout=1; no grant while m_busy is forced high afterwards.
- Reset mid-XFER: rst_n low for 3 cycles during a read -> all outputs 0 asynchronously, no done; after release req[1] is granted first (rr_ptr reset).

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: widths, the request arbiter FSM states and the
// i2c_master state encodings referenced by the existing benches.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [3:0] {
    MST_IDLE     = 4'd0,
    MST_START    = 4'd1,
    MST_ADDR     = 4'd2,
    MST_ADDR_ACK = 4'd3,
    MST_TX       = 4'd4,
    MST_TX_ACK   = 4'd5,
    MST_RX       = 4'd6,
    MST_RX_ACK   = 4'd7,
    MST_STOP     = 4'd8
  } i2c_mst_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around; one-hot grant plus an any-request flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW:0]   sum_s;
  logic [PW-1:0] idx_s;
  logic          found_s;
  logic          hit_s;

  // scan N candidates starting at ptr+1; only the first hit is granted
  always_comb begin
    gnt     = '0;
    sum_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      sum_s   = {1'b0, ptr} + (PW+1)'(i);
      sum_s   = (sum_s >= (PW+1)'(N)) ? (sum_s - (PW+1)'(N)) : sum_s;
      idx_s   = sum_s[PW-1:0];
      hit_s   = req[idx_s] & ~found_s;
      gnt     = gnt | ({{(N-1){1'b0}}, hit_s} << idx_s);
      found_s = found_s | hit_s;
    end
    valid = |req;
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one i2c_master between N_REQ requesters: round-robin grant, latched
// transaction fields, master handshake, timeout abort and response routing.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [I2C_ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [I2C_DATA_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]              req_rw,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              done,
  output logic [I2C_DATA_W-1:0]         resp_data,
  output logic                          resp_err,
  output logic                          resp_timeout,
  output logic                          m_start,
  output logic [I2C_ADDR_W-1:0]         m_addr,
  output logic [I2C_DATA_W-1:0]         m_tx_byte,
  output logic                          m_rw,
  input  logic [I2C_DATA_W-1:0]         m_rx_byte,
  input  logic                          m_rx_valid,
  input  logic                          m_busy,
  input  logic                          m_ack_error
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  arb_state_t                state_r, state_nxt_s;
  logic [PW-1:0]             rr_ptr_r, rr_ptr_nxt_s;
  logic [CW-1:0]             cnt_r, cnt_nxt_s;
  logic                      rx_seen_r, rx_seen_nxt_s;
  logic [N_REQ-1:0]          gnt_r, gnt_nxt_s, done_r, done_nxt_s;
  logic [I2C_DATA_W-1:0]     resp_data_r, resp_data_nxt_s;
  logic                      resp_err_r, resp_err_nxt_s;
  logic                      resp_timeout_r, resp_timeout_nxt_s;
  logic                      m_start_r, m_start_nxt_s;
  logic [I2C_ADDR_W-1:0]     m_addr_r, m_addr_nxt_s;
  logic [I2C_DATA_W-1:0]     m_tx_byte_r, m_tx_byte_nxt_s;
  logic                      m_rw_r, m_rw_nxt_s;

  logic [N_REQ-1:0]          arb_gnt_s;
  logic                      arb_valid_s;
  logic [PW-1:0]             win_idx_s;
  logic [I2C_ADDR_W-1:0]     win_addr_s;
  logic [I2C_DATA_W-1:0]     win_data_s;
  logic                      win_rw_s;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req   (req),
    .ptr   (rr_ptr_r),
    .gnt   (arb_gnt_s),
    .valid (arb_valid_s)
  );

  // one-hot mux of the winner's index and request fields
  always_comb begin
    win_idx_s  = '0;
    win_addr_s = '0;
    win_data_s = '0;
    win_rw_s   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      win_idx_s  = win_idx_s | (arb_gnt_s[i] ? PW'(i) : {PW{1'b0}});
      win_addr_s = win_addr_s | ({I2C_ADDR_W{arb_gnt_s[i]}} & req_addr[I2C_ADDR_W*i +: I2C_ADDR_W]);
      win_data_s = win_data_s | ({I2C_DATA_W{arb_gnt_s[i]}} & req_data[I2C_DATA_W*i +: I2C_DATA_W]);
      win_rw_s   = win_rw_s | (arb_gnt_s[i] & req_rw[i]);
    end
  end

  // next-state and next-output logic of the arbitration FSM
  always_comb begin
    state_nxt_s        = state_r;
    rr_ptr_nxt_s       = rr_ptr_r;
    cnt_nxt_s          = cnt_r;
    rx_seen_nxt_s      = rx_seen_r;
    gnt_nxt_s          = gnt_r;
    done_nxt_s         = '0;
    resp_data_nxt_s    = resp_data_r;
    resp_err_nxt_s     = resp_err_r;
    resp_timeout_nxt_s = resp_timeout_r;
    m_start_nxt_s      = m_start_r;
    m_addr_nxt_s       = m_addr_r;
    m_tx_byte_nxt_s    = m_tx_byte_r;
    m_rw_nxt_s         = m_rw_r;
    case (state_r)
      IDLE: begin
        // a busy master (foreign or aborted transfer) blocks any new grant
        if (arb_valid_s && !m_busy) begin
          gnt_nxt_s          = arb_gnt_s;
          rr_ptr_nxt_s       = win_idx_s;
          m_addr_nxt_s       = win_addr_s;
          m_tx_byte_nxt_s    = win_data_s;
          m_rw_nxt_s         = win_rw_s;
          m_start_nxt_s      = 1'b1;
          cnt_nxt_s          = '0;
          rx_seen_nxt_s      = 1'b0;
          resp_data_nxt_s    = '0;
          resp_err_nxt_s     = 1'b0;
          resp_timeout_nxt_s = 1'b0;
          state_nxt_s        = ISSUE;
        end else begin
          gnt_nxt_s = '0;
        end
      end
      ISSUE, XFER: begin
        if (cnt_r == TO_LAST) begin
          m_start_nxt_s      = 1'b0;
          resp_err_nxt_s     = 1'b1;
          resp_timeout_nxt_s = 1'b1;
          done_nxt_s         = gnt_r;
          state_nxt_s        = RESP;
        end else if (state_r == ISSUE) begin
          cnt_nxt_s     = cnt_r + CW'(1);
          m_start_nxt_s = ~m_busy;
          state_nxt_s   = m_busy ? XFER : ISSUE;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
          // late capture covers masters that never pulse rx_valid
          if (m_rw_r && (m_rx_valid || (!m_busy && !rx_seen_r))) begin
            resp_data_nxt_s = m_rx_byte;
            rx_seen_nxt_s   = 1'b1;
          end else begin
            rx_seen_nxt_s = rx_seen_r;
          end
          if (!m_busy) begin
            resp_err_nxt_s = m_ack_error;
            done_nxt_s     = gnt_r;
            state_nxt_s    = RESP;
          end else begin
            state_nxt_s = XFER;
          end
        end
      end
      RESP: begin
        gnt_nxt_s     = '0;
        m_start_nxt_s = 1'b0;
        state_nxt_s   = IDLE;
      end
      default: begin
        gnt_nxt_s     = '0;
        m_start_nxt_s = 1'b0;
        state_nxt_s   = IDLE;
      end
    endcase
  end

  // state, pointer, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      rr_ptr_r       <= PW'(N_REQ - 1);
      cnt_r          <= '0;
      rx_seen_r      <= 1'b0;
      gnt_r          <= '0;
      done_r         <= '0;
      resp_data_r    <= '0;
      resp_err_r     <= 1'b0;
      resp_timeout_r <= 1'b0;
      m_start_r      <= 1'b0;
      m_addr_r       <= '0;
      m_tx_byte_r    <= '0;
      m_rw_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      rr_ptr_r       <= rr_ptr_nxt_s;
      cnt_r          <= cnt_nxt_s;
      rx_seen_r      <= rx_seen_nxt_s;
      gnt_r          <= gnt_nxt_s;
      done_r         <= done_nxt_s;
      resp_data_r    <= resp_data_nxt_s;
      resp_err_r     <= resp_err_nxt_s;
      resp_timeout_r <= resp_timeout_nxt_s;
      m_start_r      <= m_start_nxt_s;
      m_addr_r       <= m_addr_nxt_s;
      m_tx_byte_r    <= m_tx_byte_nxt_s;
      m_rw_r         <= m_rw_nxt_s;
    end
  end

  assign gnt          = gnt_r;
  assign done         = done_r;
  assign resp_data    = resp_data_r;
  assign resp_err     = resp_err_r;
  assign resp_timeout = resp_timeout_r;
  assign m_start      = m_start_r;
  assign m_addr       = m_addr_r;
  assign m_tx_byte    = m_tx_byte_r;
  assign m_rw         = m_rw_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: the bench plays the i2c_master and checks grants
// and responses against a round-robin reference model.
module tb_i2c_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, req_rw, gnt, done;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_data;
  logic [7:0]    resp_data, m_tx_byte, m_rx_byte;
  logic          resp_err, resp_timeout, m_start, m_rw, m_rx_valid, m_busy, m_ack_error;
  logic [6:0]    m_addr;

  int total = 0;
  int bad   = 0;
  int last  = N - 1;
  int w, n;
  logic [6:0] fa [N];
  logic [7:0] fd [N];
  logic       fr [N];

  i2c_req_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_rw(req_rw), .gnt(gnt), .done(done), .resp_data(resp_data), .resp_err(resp_err),
    .resp_timeout(resp_timeout), .m_start(m_start), .m_addr(m_addr), .m_tx_byte(m_tx_byte),
    .m_rw(m_rw), .m_rx_byte(m_rx_byte), .m_rx_valid(m_rx_valid), .m_busy(m_busy),
    .m_ack_error(m_ack_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference rule: first requester after the previous winner, wrapping
  function automatic int rr_pick(input logic [N-1:0] m, input int lst);
    for (int k = 1; k <= N; k++) begin
      if (m[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
    fa[i] = a; fd[i] = d; fr[i] = rw;
    req_addr[7*i +: 7] = a;
    req_data[8*i +: 8] = d;
    req_rw[i]          = rw;
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  // master emulation for one transaction granted to requester wi
  task automatic run_txn(input int wi, input logic [7:0] rx, input logic nack, input int dly,
                         input int blen, input logic use_valid, input logic scramble);
    int lat;
    wait_gnt(lat);
    chk("gnt_latency", lat, 1);
    chk("gnt_onehot", gnt, 1 << wi);
    chk("m_start_set", m_start, 1);
    chk("m_addr", m_addr, fa[wi]);
    chk("m_tx_byte", m_tx_byte, fd[wi]);
    chk("m_rw", m_rw, fr[wi]);
    if (scramble) begin
      req      = 4'($urandom);
      req_addr = 28'($urandom);
      req_data = $urandom;
      req_rw   = 4'($urandom);
    end
    repeat (dly) begin
      @(negedge clk);
      chk("m_start_hold", m_start, 1);
    end
    m_busy = 1'b1;
    @(negedge clk);
    chk("m_start_drop", m_start, 0);
    repeat (blen) @(negedge clk);
    if (fr[wi] && use_valid) begin
      m_rx_valid = 1'b1;
      m_rx_byte  = rx;
      @(negedge clk);
      m_rx_valid = 1'b0;
      m_rx_byte  = ~rx;
    end else begin
      m_rx_byte = rx;
    end
    m_busy      = 1'b0;
    m_ack_error = nack;
    @(negedge clk);
    chk("done_pulse", done, 1 << wi);
    chk("gnt_at_done", gnt, 1 << wi);
    chk("resp_data", resp_data, fr[wi] ? rx : 8'h00);
    chk("resp_err", resp_err, nack);
    chk("resp_timeout", resp_timeout, 0);
    chk("m_addr_stable", m_addr, fa[wi]);
    m_ack_error = 1'b0;
    @(negedge clk);
    chk("done_drop", done, 0);
    chk("gnt_drop", gnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_data = '0;
    m_rx_byte = 8'h00; m_rx_valid = 1'b0; m_busy = 1'b0; m_ack_error = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_resp", {resp_data, resp_err, resp_timeout}, 0);
    chk("rst_master", {m_start, m_addr, m_tx_byte, m_rw}, 0);
    rst_n = 1'b1;

    // contention: all four held high from reset
    for (int i = 0; i < N; i++) set_req(i, 7'(8'h10 + i), 8'(8'hC0 + i), 1'(i % 2));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = k % N;
      last = w;
      run_txn(w, 8'(8'h30 + k), 1'b0, k % 3, 2, 1'b1, 1'b0);
    end
    req = '0;

    // single write then read-back
    set_req(0, 7'h50, 8'hA5, 1'b0);
    req = 4'b0001; last = 0;
    run_txn(0, 8'h77, 1'b0, 1, 3, 1'b0, 1'b0);
    set_req(2, 7'h50, 8'h00, 1'b1);
    req = 4'b0100; last = 2;
    run_txn(2, 8'hA5, 1'b0, 0, 4, 1'b1, 1'b0);

    // NACK, then a normal request is still served
    set_req(3, 7'h22, 8'h11, 1'b0);
    req = 4'b1000; last = 3;
    run_txn(3, 8'h00, 1'b1, 0, 2, 1'b0, 1'b0);
    set_req(1, 7'h2B, 8'h3C, 1'b1);
    req = 4'b0010; last = 1;
    run_txn(1, 8'h9E, 1'b0, 2, 1, 1'b0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) set_req(i, 7'($urandom), 8'($urandom), 1'($urandom));
      req = 4'($urandom_range(1, 15));
      w = rr_pick(req, last);
      last = w;
      run_txn(w, 8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
              $urandom_range(0, 5), 1'($urandom), 1'b1);
    end

    // timeout with the master never going busy
    set_req(0, 7'h3C, 8'h5A, 1'b0);
    req = 4'b0001; last = 0;
    wait_gnt(n);
    chk("to_gnt_latency", n, 1);
    chk("to_gnt", gnt, 4'b0001);
    n = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (i == TO - 1) chk("to_start_hold", m_start, 1);
      if (done != '0) begin
        n = i;
        break;
      end
    end
    chk("to_cycles", n, TO);
    chk("to_done", done, 4'b0001);
    chk("to_err", resp_err, 1);
    chk("to_flag", resp_timeout, 1);
    chk("to_start_drop", m_start, 0);
    m_busy = 1'b1;
    @(negedge clk);
    chk("to_done_drop", done, 0);
    req = 4'b0101;
    set_req(2, 7'h41, 8'h42, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("busy_no_gnt", gnt, 0);
      chk("busy_no_start", m_start, 0);
    end
    m_busy = 1'b0;
    w = rr_pick(req, last);
    last = w;
    run_txn(w, 8'h5D, 1'b0, 0, 2, 1'b1, 1'b0);

    // reset in the middle of a read by requester 1
    set_req(1, 7'h61, 8'h00, 1'b1);
    req = 4'b0010;
    wait_gnt(n);
    chk("rst_txn_gnt", gnt, 4'b0010);
    m_busy = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_master", {m_start, m_addr, m_tx_byte, m_rw}, 0);
    chk("async_rst_resp", {done, resp_data, resp_err, resp_timeout}, 0);
    m_busy = 1'b0;
    set_req(1, 7'h12, 8'h34, 1'b0);
    set_req(2, 7'h56, 8'h78, 1'b0);
    req = 4'b0110;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    last = N - 1;
    run_txn(1, 8'h00, 1'b0, 0, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
